// File: rtl/serial_pair_serializer_msb_first_pkg.sv
// rtl/serial_pair_serializer_msb_first_pkg.sv - shared types and helpers for the pair serializer
package serial_pair_pkg;

    localparam int SERIAL_PAIR_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        LESS,
        EQ,
        GREATER
    } cmp_result_t;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // Encodes a compare result as {less, eq, greater}
    function automatic logic [2:0] to_onehot(input cmp_result_t r);
        logic [2:0] oh;
        oh = 3'b000;
        case (r)
            LESS:    oh = 3'b100;
            EQ:      oh = 3'b010;
            GREATER: oh = 3'b001;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/serial_pair_serializer_msb_first_if.sv
// rtl/serial_pair_serializer_msb_first_if.sv - pair input handshake and serial output bundle (SERIAL_PAIR_SER_STALL_EN adds ser_ready)
interface serial_pair_serializer_msb_first_if
    import serial_pair_pkg::*;
#(
    parameter int WIDTH = SERIAL_PAIR_DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             ser_valid;
    logic             ser_a;
    logic             ser_b;
    logic             ser_first;
    logic             ser_last;
    logic             exp_less;
    logic             exp_eq;
    logic             exp_greater;
`ifdef SERIAL_PAIR_SER_STALL_EN
    logic             ser_ready;

    modport master (
        output in_valid, in_a, in_b, ser_ready,
        input  in_ready, ser_valid, ser_a, ser_b, ser_first, ser_last,
               exp_less, exp_eq, exp_greater
    );

    modport slave (
        input  in_valid, in_a, in_b, ser_ready,
        output in_ready, ser_valid, ser_a, ser_b, ser_first, ser_last,
               exp_less, exp_eq, exp_greater
    );
`else
    modport master (
        output in_valid, in_a, in_b,
        input  in_ready, ser_valid, ser_a, ser_b, ser_first, ser_last,
               exp_less, exp_eq, exp_greater
    );

    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready, ser_valid, ser_a, ser_b, ser_first, ser_last,
               exp_less, exp_eq, exp_greater
    );
`endif

endinterface

// File: rtl/serial_pair_serializer_msb_first_shifter.sv
// rtl/serial_pair_serializer_msb_first_shifter.sv - single-lane parallel-in serial-out register, MSB first
module msb_first_shifter
    import serial_pair_pkg::*;
#(
    parameter int WIDTH = SERIAL_PAIR_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] sh;

    // Load wins over shift; neither asserted holds the lane
    always_ff @(posedge clk) begin
        if (rst) begin
            sh <= '0;
        end else if (load) begin
            sh <= din;
        end else if (shift) begin
            sh <= {sh[WIDTH-2:0], 1'b0};
        end
    end

    assign dout = sh[WIDTH-1];

endmodule

// File: rtl/serial_pair_serializer_msb_first.sv
// rtl/serial_pair_serializer_msb_first.sv - MSB-first operand pair serializer with golden compare (SERIAL_PAIR_SER_STALL_EN enables ser_ready throttling)
module serial_pair_serializer_msb_first
    import serial_pair_pkg::*;
#(
    parameter int WIDTH = SERIAL_PAIR_DEFAULT_WIDTH
) (
    input logic                               clk,
    input logic                               rst,
    serial_pair_serializer_msb_first_if.slave bus
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [2:0]    exp_q;
    logic [2:0]    exp_next;
    logic          load;
    logic          shift;
    logic          advance;
    logic          at_last;
    logic          ser_valid;
    logic          in_ready;
    logic          accept;
    cmp_result_t   cmp_in;

`ifdef SERIAL_PAIR_SER_STALL_EN
    assign advance = bus.ser_ready;
`else
    assign advance = 1'b1;
`endif

    assign ser_valid = (state == SHIFT);
    assign at_last   = (cnt == LAST);
    // The final bit may hand over to a new word in the same cycle it leaves
    assign in_ready  = !ser_valid | (at_last & advance);
    assign accept    = bus.in_valid & in_ready;

    // Golden unsigned compare of the pair being offered
    always_comb begin
        cmp_in = GREATER;
        if (bus.in_a < bus.in_b) begin
            cmp_in = LESS;
        end else if (bus.in_a == bus.in_b) begin
            cmp_in = EQ;
        end
    end

    // State, bit counter and golden result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            exp_q <= 3'b000;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            exp_q <= exp_next;
        end
    end

    // Next-state: load on accept, shift while mid-word, drop to idle after the LSB
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        exp_next   = exp_q;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load       = 1'b1;
                    cnt_next   = '0;
                    exp_next   = to_onehot(cmp_in);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (advance) begin
                    if (!at_last) begin
                        shift    = 1'b1;
                        cnt_next = cnt + CW'(1);
                    end else if (accept) begin
                        load     = 1'b1;
                        cnt_next = '0;
                        exp_next = to_onehot(cmp_in);
                    end else begin
                        cnt_next   = '0;
                        exp_next   = 3'b000;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                exp_next   = 3'b000;
            end
        endcase
    end

    msb_first_shifter #(.WIDTH(WIDTH)) u_lane_a (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (bus.in_a),
        .dout  (bus.ser_a)
    );

    msb_first_shifter #(.WIDTH(WIDTH)) u_lane_b (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (bus.in_b),
        .dout  (bus.ser_b)
    );

    assign bus.in_ready    = in_ready;
    assign bus.ser_valid   = ser_valid;
    assign bus.ser_first   = ser_valid & (cnt == '0);
    assign bus.ser_last    = ser_valid & at_last;
    assign bus.exp_less    = exp_q[2];
    assign bus.exp_eq      = exp_q[1];
    assign bus.exp_greater = exp_q[0];

endmodule

// File: doc/serial_pair_serializer_msb_first.md
Name: serial_pair_serializer_msb_first

Overview:
Parallel-to-serial transmitter for operand pairs. Accepts two WIDTH-bit words (a, b) over a valid/ready handshake and shifts both out in lockstep, one bit per cycle, most significant bit first. Word boundaries are marked with first/last flags. Output is the bit-serial stream consumed by the MSB-first serial comparator datapath. The block also emits the golden less/eq/greater result for the word so downstream checkers can self-verify.

Parameters:
WIDTH, 8, operand width in bits; legal range is WIDTH >= 2.

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high; clock clk
in_valid  in  1  upstream pair valid
in_ready  out  1  block can accept a pair this cycle
in_a  in  WIDTH  operand a
in_b  in  WIDTH  operand b
ser_valid  out  1  ser_a/ser_b carry a valid bit
ser_a  out  1  serial bit of a, MSB first
ser_b  out  1  serial bit of b, MSB first
ser_first  out  1  current bit is the MSB of the word
ser_last  out  1  current bit is the LSB of the word
exp_less  out  1  golden a<b (unsigned); held for the whole word
exp_eq  out  1  golden a==b; held for the whole word
exp_greater  out  1  golden a>b; held for the whole word

Behaviour:
- Reset values: ser_valid=0, ser_a=0, ser_b=0, ser_first=0, ser_last=0, exp_*=0, in_ready=1, shift registers=0, bit counter=0.
- States:
  - IDLE (ser_valid=0).
  - SHIFT (ser_valid=1), with bit counter cnt in 0..WIDTH-1, width $clog2(WIDTH).
- Accept occurs on in_valid & in_ready at a posedge. It loads sh_a<=in_a and sh_b<=in_b, sets cnt<=0 and ser_valid<=1, and registers exp_* from an unsigned compare of in_a vs in_b.
- Latency: a pair accepted at edge N presents its MSB during cycle N+1 and its LSB during cycle N+WIDTH.
- Output mapping: ser_a=sh_a[WIDTH-1], ser_b=sh_b[WIDTH-1], ser_first=ser_valid&(cnt==0), ser_last=ser_valid&(cnt==WIDTH-1).
- SHIFT, advance cycle with cnt<WIDTH-1: shift both registers left by 1 (zero fill) and increment cnt.
- SHIFT, advance cycle with cnt==WIDTH-1:
  - if an accept occurs in the same cycle, load the new pair (zero-bubble back-to-back);
  - otherwise clear ser_valid and return to IDLE.
- in_ready = !ser_valid | (ser_last & advance). in_ready is combinational from state and is never asserted for a word still mid-stream.
- Upstream rule: in_a, in_b and in_valid must stay stable while in_valid & !in_ready. The bench asserts this.
- exp_* are one-hot while ser_valid=1 and all zero in IDLE. They change only on load.
- Reset mid-word: the word is discarded; the next cycle is IDLE with reset values. No ser_last is produced for the truncated word.
- A simultaneous rst and in_valid: rst wins and nothing is accepted.

Optional Feature:
SERIAL_PAIR_SER_STALL_EN:
- Defined: adds input port ser_ready (1 bit). advance = ser_ready. When ser_ready=0 in SHIFT, sh_*, cnt and every ser_*/exp_* output hold unchanged, and in_ready stays 0 unless in IDLE.
- Undefined: the port is absent, advance is constant 1, and the stream is never throttled.

Decomposition:
- Package serial_pair_pkg:
  - cmp_result_t (enum LESS, EQ, GREATER), used internally to encode exp_*;
  - function to_onehot(cmp_result_t);
  - constant SERIAL_PAIR_DEFAULT_WIDTH=8.
- Sub-module msb_first_shifter: a single-lane WIDTH-bit parallel-in/serial-out register with load, shift and hold controls. It is instantiated twice (a and b lanes). The top level owns cnt, the FSM, the handshake and the golden compare.

Test Plan:
1. WIDTH=4; reset, then accept a=4'b1010, b=4'b1001 at edge 0 -> cycles 1..4 give ser_a=1,0,1,0 and ser_b=1,0,0,1; ser_first at cycle 1, ser_last at cycle 4; exp_greater=1 throughout; in_ready=0 in cycles 1-3.
2. Back-to-back: second pair a=4'h3, b=4'h3 held on in_valid from cycle 2 -> accepted in cycle 4 (in_ready=1 with ser_last); its MSB appears in cycle 5 with no bubble; exp_eq=1 in cycles 5-8; ser_valid drops in cycle 9.
3. Extremes: a=4'h0, b=4'hF -> exp_less=1, ser_b=1,1,1,1 and ser_a=0,0,0,0. Then a=b=4'hF -> exp_eq=1.
4. Reset mid-word: assert rst while cnt==2 -> next cycle ser_valid=0, in_ready=1, no ser_last seen; a fresh pair afterwards streams normally.
5. (SERIAL_PAIR_SER_STALL_EN) ser_ready=0 for 3 cycles while cnt==1 -> ser_a, ser_b and ser_first/ser_last are frozen; ser_last arrives 3 cycles later than unstalled; in_ready stays 0 during the stall.
6. WIDTH=8 random 200 pairs with random in_valid gaps -> a scoreboard deserializes the stream, and the reconstructed words and exp_* match the accepted inputs exactly.
